grayscale_window: RTL and testbench

//  - Parametrised RGB->gray window loader: accepts addressed RGB pixels over a valid/ready

---
 rtl/grayscale_window.sv | 98 +++++++++
 tb/tb_grayscale_window.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_window.sv
// RGB->luma window loader: handshake-fed 2-stage fixed-point conversion into a WIN-slot window.
// Define GRAY_ROUND_EN for round-half-up luma; default build truncates.
module grayscale_window #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned WIN    = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [3*PIX_W-1:0]     in_rgb,
  input  logic                   win_clr,
  output logic [WIN*PIX_W-1:0]   win_gray,
  output logic [WIN-1:0]         win_mask,
  output logic                   win_full,
  output logic                   addr_err
);

  typedef logic [PIX_W+7:0] prod_t;
  typedef logic [PIX_W+9:0] sum_t;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  prod_t             p_r, p_g, p_b;

  logic              accept;
  logic              addr_ok;
  sum_t              sum;
  sum_t              sum_adj;
  logic [PIX_W-1:0]  gray;
  logic [WIN-1:0]    mask_nxt;

  // rst gates ready so nothing is taken while the block is held in reset.
  assign in_ready = !rst && !win_full && !win_clr;
  assign accept   = in_valid && in_ready;
  assign addr_ok  = 32'(s1_addr) < WIN;

  always_comb begin
    sum = sum_t'(p_r) + sum_t'(p_g) + sum_t'(p_b);
`ifdef GRAY_ROUND_EN
    sum_adj = sum + sum_t'(128);
`else
    sum_adj = sum;
`endif
    // Weights total 256, so the shifted result always fits PIX_W bits.
    gray = PIX_W'(sum_adj >> 8);
  end

  always_comb begin
    mask_nxt = win_mask;
    if (s1_valid && addr_ok) begin
      for (int unsigned k = 0; k < WIN; k++) begin
        if (32'(s1_addr) == k) mask_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      p_r      <= '0;
      p_g      <= '0;
      p_b      <= '0;
      win_gray <= '0;
      win_mask <= '0;
      win_full <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (win_clr) begin
        // Flush in-flight pixels; window data stays readable.
        s1_valid <= 1'b0;
        win_mask <= '0;
        win_full <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          s1_addr <= in_addr;
          p_r     <= prod_t'(in_rgb[3*PIX_W-1 -: PIX_W]) * prod_t'(77);
          p_g     <= prod_t'(in_rgb[2*PIX_W-1 -: PIX_W]) * prod_t'(153);
          p_b     <= prod_t'(in_rgb[PIX_W-1 -: PIX_W]) * prod_t'(26);
        end
        if (s1_valid && addr_ok) begin
          for (int unsigned k = 0; k < WIN; k++) begin
            if (32'(s1_addr) == k) win_gray[k*PIX_W +: PIX_W] <= gray;
          end
        end
        win_mask <= mask_nxt;
        win_full <= &mask_nxt;
        addr_err <= s1_valid && !addr_ok;
      end
    end
  end

endmodule

// File: tb/tb_grayscale_window.sv
// Randomized self-checking bench for grayscale_window against a queue-based luma model.
module tb_grayscale_window;
  localparam int PIX_W  = 8;
  localparam int WIN    = 9;
  localparam int ADDR_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_addr = '0;
  logic [3*PIX_W-1:0]   in_rgb = '0;
  logic                 win_clr = 1'b0;
  logic [WIN*PIX_W-1:0] win_gray;
  logic [WIN-1:0]       win_mask;
  logic                 win_full;
  logic                 addr_err;

  int total = 0;
  int bad   = 0;

  grayscale_window #(.PIX_W(PIX_W), .WIN(WIN), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_rgb   (in_rgb),
    .win_clr  (win_clr),
    .win_gray (win_gray),
    .win_mask (win_mask),
    .win_full (win_full),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  // Reference model: accepted pixels queue up and land in the window one edge later.
  typedef struct {int addr; int gray;} pend_t;
  pend_t          q[$];
  int             m_gray[WIN];
  bit [WIN-1:0]   m_mask = '0;
  bit             m_full = 1'b0;
  bit             m_err  = 1'b0;

  function automatic int luma(input int r, input int g, input int b);
    int s;
    s = 77 * r + 153 * g + 26 * b;
`ifdef GRAY_ROUND_EN
    s = s + 128;
`endif
    return s / 256;
  endfunction

  function automatic bit m_ready();
    return !rst && !m_full && !win_clr;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      foreach (m_gray[k]) m_gray[k] = 0;
      m_mask = '0;
      m_full = 1'b0;
      m_err  = 1'b0;
    end else begin
      bit    acc;
      pend_t p;
      acc   = in_valid && !m_full && !win_clr;
      m_err = 1'b0;
      if (win_clr) begin
        q.delete();
        m_mask = '0;
        m_full = 1'b0;
      end else begin
        if (q.size() > 0) begin
          p = q.pop_front();
          if (p.addr < WIN) begin
            m_gray[p.addr] = p.gray;
            m_mask[p.addr] = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
        m_full = (m_mask == {WIN{1'b1}});
        if (acc) begin
          p.addr = int'(in_addr);
          p.gray = luma(int'(in_rgb[23:16]), int'(in_rgb[15:8]), int'(in_rgb[7:0]));
          q.push_back(p);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [WIN*PIX_W-1:0] ev;
    for (int k = 0; k < WIN; k++) ev[k*PIX_W +: PIX_W] = PIX_W'(m_gray[k]);
    chk("in_ready", 128'(in_ready), 128'(m_ready()));
    chk("win_gray", 128'(win_gray), 128'(ev));
    chk("win_mask", 128'(win_mask), 128'(m_mask));
    chk("win_full", 128'(win_full), 128'(m_full));
    chk("addr_err", 128'(addr_err), 128'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int r, input int g, input int b);
    in_valid = v;
    in_addr  = ADDR_W'(a);
    in_rgb   = {8'(r), 8'(g), 8'(b)};
  endtask

  function automatic logic [PIX_W-1:0] slot(input int k);
    return win_gray[k*PIX_W +: PIX_W];
  endfunction

  initial begin
    logic [WIN*PIX_W-1:0] all_ff;
    bit clr_prev;
    all_ff = '1;

    repeat (3) step();
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_gray", 128'(win_gray), 128'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 128'(in_ready), 128'(1));

    // Single pixel: 7700+30600+1300=39600 -> 154 (155 rounded)
    drive(1, 3, 100, 200, 50);
    step();
    drive(0, 0, 0, 0, 0);
    step();
`ifdef GRAY_ROUND_EN
    chk("slot3", 128'(slot(3)), 128'(155));
`else
    chk("slot3", 128'(slot(3)), 128'(154));
`endif
    chk("mask_single", 128'(win_mask), 128'(9'h008));
    chk("full_single", 128'(win_full), 128'(0));

    // Fill the window back to back
    for (int i = 0; i < WIN; i++) begin
      drive(1, i, 255, 255, 255);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("not_full_yet", 128'(win_full), 128'(0));
    step();
    chk("full_set", 128'(win_full), 128'(1));
    chk("ready_drop", 128'(in_ready), 128'(0));
    chk("all_ff", 128'(win_gray), 128'(all_ff));

    // Clear reopens, data retained
    win_clr = 1'b1;
    #1;
    chk("ready_in_clr", 128'(in_ready), 128'(0));
    step();
    win_clr = 1'b0;
    #1;
    chk("clr_mask", 128'(win_mask), 128'(0));
    chk("clr_full", 128'(win_full), 128'(0));
    chk("clr_ready", 128'(in_ready), 128'(1));
    chk("clr_keep", 128'(win_gray), 128'(all_ff));

    // Out-of-range address
    drive(1, 12, 10, 10, 10);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("err_pulse", 128'(addr_err), 128'(1));
    chk("err_mask", 128'(win_mask), 128'(0));
    chk("err_gray", 128'(win_gray), 128'(all_ff));
    step();
    chk("err_end", 128'(addr_err), 128'(0));

    // Clear flushes an in-flight pixel
    drive(1, 5, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    win_clr = 1'b1;
    step();
    win_clr = 1'b0;
    step();
    chk("flush_slot5", 128'(slot(5)), 128'(255));
    chk("flush_mask", 128'(win_mask), 128'(0));

    // Reset with pixels in flight
    drive(1, 1, 1, 2, 3);
    step();
    drive(1, 2, 4, 5, 6);
    step();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_mask", 128'(win_mask), 128'(0));
    chk("arst_gray", 128'(win_gray), 128'(0));
    chk("arst_ready", 128'(in_ready), 128'(0));
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("arst_nowrite", 128'(win_mask), 128'(0));

    // Randomized traffic
    clr_prev = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
      if (!clr_prev && (m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0)))
        win_clr = 1'b1;
      else
        win_clr = 1'b0;
      clr_prev = win_clr;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    drive(0, 0, 0, 0, 0);
    win_clr = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
